// File: rtl/ksa_word_sequencer_pkg.sv
// Shared definitions for the byte-serial KSA word sequencer.
package ksa_word_sequencer_pkg;

  // Width of one KSA slice (one limb).
  localparam int KSA_W = 8;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ksa_word_sequencer_ksa.sv
// 8-bit Kogge-Stone adder slice, purely combinational.
// The carry-in is folded into the bit-0 generate term, so each group
// generate at level 3 is directly the carry out of that bit position.
module ksa_word_sequencer_ksa
  import ksa_word_sequencer_pkg::*;
(
  input  logic [KSA_W-1:0] A,
  input  logic [KSA_W-1:0] B,
  input  logic             Cin,
  output logic [KSA_W-1:0] Sum,
  output logic             Cout
);

  logic [KSA_W-1:0] p0, g0, p1, g1, p2, g2, g3;

  // Bitwise propagate/generate, carry-in merged into bit 0.
  always_comb begin
    p0    = A ^ B;
    g0    = A & B;
    g0[0] = (A[0] & B[0]) | (p0[0] & Cin);
  end

  // Prefix level, span 1.
  always_comb begin
    g1 = g0;
    p1 = p0;
    for (int unsigned i = 1; i < KSA_W; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end
  end

  // Prefix level, span 2.
  always_comb begin
    g2 = g1;
    p2 = p1;
    for (int unsigned i = 2; i < KSA_W; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end
  end

  // Prefix level, span 4 (propagate no longer needed after this).
  always_comb begin
    g3 = g2;
    for (int unsigned i = 4; i < KSA_W; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
    end
  end

  // Sum bits from propagate and incoming carries.
  always_comb begin
    Sum  = p0 ^ {g3[KSA_W-2:0], Cin};
    Cout = g3[KSA_W-1];
  end

endmodule

// File: rtl/ksa_word_sequencer.sv
// Byte-serial multi-word adder: feeds one limb per cycle (LSB first)
// through a single 8-bit KSA slice, returning sum, carry-out and signed
// overflow over valid/ready handshakes.
module ksa_word_sequencer
  import ksa_word_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [KSA_W*NBYTES-1:0]   A,
  input  logic [KSA_W*NBYTES-1:0]   B,
  input  logic                      Cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [KSA_W*NBYTES-1:0]   Sum,
  output logic                      Cout,
  output logic                      Ovf
);

  localparam int W     = KSA_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  state_t           state;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             a_msb;
  logic             b_msb;
  logic [KSA_W-1:0] byte_sum;
  logic             byte_cout;

  ksa_word_sequencer_ksa u_ksa (
    .A    (a_sh[KSA_W-1:0]),
    .B    (b_sh[KSA_W-1:0]),
    .Cin  (carry),
    .Sum  (byte_sum),
    .Cout (byte_cout)
  );

  // Ready only in IDLE and never while reset is asserted.
  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  // Control FSM with operand shift registers, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            idx   <= '0;
            a_msb <= A[W-1];
            b_msb <= B[W-1];
            state <= RUN;
          end
        end
        RUN: begin
          a_sh                    <= a_sh >> KSA_W;
          b_sh                    <= b_sh >> KSA_W;
          Sum[idx*KSA_W +: KSA_W] <= byte_sum;
          carry                   <= byte_cout;
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            Cout      <= byte_cout;
            // Top byte is being written this edge, so its MSB is the final sum MSB.
            Ovf       <= (a_msb == b_msb) && (byte_sum[KSA_W-1] != a_msb);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
